// File: rtl/ula_pkg.sv
// Shared ULA definitions: datapath width, divider FSM encoding, divide-by-zero quotient.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ula_pkg;

  parameter int WIDTH = 32;

  parameter logic [1:0] S_IDLE = 2'd0;
  parameter logic [1:0] S_CALC = 2'd1;
  parameter logic [1:0] S_DONE = 2'd2;

  // Quotient reported when the divisor is zero.
  parameter logic [WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/subtrator_33bit.sv
// Trial-subtract stage: diff = x - y (mod 2^33), borrow = (x < y).
// Latency: combinational.
// Backpressure: none.
// Ports: x, y - 33-bit operands; diff - 33-bit difference; borrow - unsigned underflow.
module subtrator_33bit (
  input  logic [32:0] x,
  input  logic [32:0] y,
  output logic [32:0] diff,
  output logic        borrow
);

  // One extra bit on top carries the true unsigned borrow out.
  assign {borrow, diff} = {1'b0, x} - {1'b0, y};

endmodule

// File: rtl/divisor_32bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Latency: done 33 cycles after the accepting edge (1 cycle for divide by zero).
// Backpressure: start is only sampled in IDLE; requests during CALC/DONE are dropped.
// Ports: clk, rst_n (async active-low); start, a (dividend), b (divisor) in;
//        busy (in CALC), done (1-cycle pulse), q, r, div_zero out, all registered
//        and held until the next done.
module divisor_32bit
  import ula_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] qs;
  logic [WIDTH-1:0] d;
  logic             dz;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             qbit;

  logic             busy_nxt;
  logic             done_nxt;
  logic             load_res;

  // Trial subtract: shift the next dividend bit into the partial remainder.
  assign t = {rem, qs[WIDTH-1]};

  subtrator_33bit u_sub (
    .x      (t),
    .y      ({1'b0, d}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Since rem < d always holds, t < 2d and diff's MSB equals the true borrow;
  // rejecting on either keeps the rule correct even if that invariant is broken.
  assign qbit = ~(diff[WIDTH] | borrow);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (b == '0) ? S_DONE : S_CALC;
      S_CALC: if (count == '0) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; the values are registered below, so every output lags the
  // state by one edge (busy covers edges k+1..k+32, done lands at k+33).
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    load_res = 1'b0;
    case (state)
      S_CALC: busy_nxt = 1'b1;
      S_DONE: begin
        done_nxt = 1'b1;
        load_res = 1'b1;
      end
      default: ;
    endcase
  end

  // Iteration datapath. Divide by zero preloads the final results into qs/rem
  // so DONE publishes both cases through the same path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      rem   <= '0;
      qs    <= '0;
      d     <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            d <= b;
            if (b == '0) begin
              qs  <= DIV0_QUOT;
              rem <= a;
              dz  <= 1'b1;
            end else begin
              qs    <= a;
              rem   <= '0;
              count <= CW'(WIDTH - 1);
              dz    <= 1'b0;
            end
          end
        end
        S_CALC: begin
          rem   <= qbit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
          qs    <= {qs[WIDTH-2:0], qbit};
          count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (load_res) begin
        q        <= qs;
        r        <= rem;
        div_zero <= dz;
      end
    end
  end

endmodule

// File: doc/divisor_32bit.md
# divisor_32bit

Multi-cycle 32-bit unsigned restoring divider for the ULA. It is the inverse-operation counterpart of the 32-bit adder path: each iteration performs one 33-bit trial subtraction, and a quotient bit is accepted or rejected based on the borrow. Operands are accepted with a start/busy/done handshake. Results remain stable for the surrounding ULA datapath until the next operation starts.

## Interface
- WIDTH, 32, operand, quotient and remainder width
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to start a division; sampled only in IDLE
- a  input  WIDTH  dividend; captured on the accepting edge
- b  input  WIDTH  divisor; captured on the accepting edge
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse; results valid from this cycle onward
- q  output  WIDTH  quotient, held until the next done
- r  output  WIDTH  remainder, held until the next done
- div_zero  output  1  divisor was 0; valid with done, held with q/r

## Operation
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0; done=0; q=0; r=0; div_zero=0; all internal registers are 0.
- FSM states are IDLE, CALC and DONE.
- IDLE + start=1, b≠0:
  - latch the dividend into the quotient shift register (qs) and the divisor into d;
  - rem=0; count=WIDTH-1;
  - next state is CALC.
- IDLE + start=1, b=0:
  - next state is DONE;
  - q=all ones; r=a; div_zero=1.
- CALC, one iteration per cycle:
  - t = {rem[WIDTH-1:0], qs[WIDTH-1]} (33 bits);
  - diff = t − {1'b0, d} (33 bits);
  - if diff[WIDTH]==0: rem=diff and the shifted-in quotient bit is 1;
  - otherwise: rem=t and the shifted-in quotient bit is 0;
  - qs is shifted left with the quotient bit entering at the LSB;
  - count decrements by 1;
  - the iteration with count==0 is the last one.
- Leaving CALC: q=final qs; r=final rem[WIDTH-1:0]; div_zero=0; next state is DONE.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE.
- start is ignored in CALC and DONE. No queuing; a request must be re-asserted in IDLE.
- a and b are don't-care outside the accepting edge.
- All arithmetic is unsigned modulo 2^33 in the trial subtract. No signed mode.

## Timing
- Start accepted at edge k:
  - busy=1 from edge k+1 through edge k+33 (exclusive);
  - q, r and done update at edge k+33;
  - done falls at edge k+34, when the state returns to IDLE;
  - the earliest next accept is edge k+34.
- Divide by zero accepted at edge k: done=1 at edge k+1, busy stays 0, IDLE again at edge k+2.
- done and busy are never both high.
- Reset asserted mid-CALC: all outputs immediately return to 0, and the operation is lost without a done pulse.
- On rst_n release, the first start can be accepted on the next rising edge.
- Registered outputs only; no combinational path from inputs to outputs.

## Structure
- Shared package (ula_pkg):
  - WIDTH default 32;
  - state encoding constants S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2;
  - DIV0_QUOT = all ones.
- One combinational sub-module, subtrator_33bit:
  - inputs x and y (33 bits);
  - outputs diff (33 bits) and borrow (1 bit);
  - it is the trial subtract stage, reusable by the ULA SUB operation.
- The top level holds the FSM, the 5-bit count, and the rem, qs, d, q and r registers.

## Test plan
- a=100, b=7, start at edge k → q=14, r=2, div_zero=0; done high only in the cycle after edge k+33; busy high for 32 cycles.
- a=32'hFFFFFFFF, b=1 → q=32'hFFFFFFFF, r=0. Then a=32'hFFFFFFFF, b=32'hFFFFFFFF → q=1, r=0.
- a=7, b=9 → q=0, r=7. Then a=0, b=5 → q=0, r=0.
- a=5, b=0 → done at edge k+1, q=32'hFFFFFFFF, r=5, div_zero=1, busy never 1.
- Start a=100/b=7, re-pulse start with a=50/b=3 at edge k+10 → the second request is ignored; result is still q=14, r=2; q and r are held after done.
- Reset pulse at edge k+16 of a division → outputs read 0 during reset and no done appears. After release, 1000/10 → q=100, r=0.
- Random sweep of 10,000 operand pairs, each checked against the a/b and a%b model at done.
